// File: rtl/axi_lite_slave_regfile_pkg.sv
// Shared constants and types for the AXI-Lite register file slave.
// Response codes and read-channel state encoding.
package axi_lite_slave_regfile_pkg;

  localparam logic [3:0] RESP_OKAY   = 4'd0;
  localparam logic [3:0] RESP_SLVERR = 4'd2;
  localparam logic [3:0] RESP_DECERR = 4'd3;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi_lite_regbank.sv
// NUM_REGS x DATA_WIDTH register bank.
// One synchronous write port, one combinational read port.
module axi_lite_regbank #(
  parameter int NUM_REGS   = 16,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

  // Storage: cleared on reset, written when the top commits a write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_lite_slave_regfile.sv
// AXI-Lite slave backed by a small register bank.
// Independent read FSM and AW/W/B write path.
module axi_lite_slave_regfile
  import axi_lite_slave_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] read_address,
  input  logic                  AR_VALID,
  output logic                  AR_READY,
  output logic [DATA_WIDTH-1:0] data_read,
  output logic                  R_VALID,
  input  logic                  R_READY,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic                  AW_VALID,
  output logic                  AW_READY,
  input  logic [DATA_WIDTH-1:0] data_write,
  input  logic                  W_VALID,
  output logic                  W_READY,
  output logic                  B_VALID,
  output logic [3:0]            BRESPONSE,
  input  logic                  B_READY
);

  localparam int IDX_W =
    (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH:0] NUM_LIM =
    (ADDR_WIDTH+1)'(NUM_REGS);

  rd_state_e             rd_state_q, rd_state_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                  aw_full_q, aw_full_d;
  logic [ADDR_WIDTH-1:0] aw_q, aw_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_q, w_d;
  logic                  b_valid_q, b_valid_d;
  logic [3:0]            bresp_q, bresp_d;

  logic                  rd_in_range;
  logic                  wr_in_range;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  aw_hs, w_hs;
  logic                  aw_eff, w_eff;
  logic                  bank_we;
  logic [DATA_WIDTH-1:0] bank_rdata;

  assign AR_READY  = (rd_state_q == RD_IDLE);
  assign R_VALID   = (rd_state_q == RD_RESP);
  assign data_read = rd_data_q;

  assign AW_READY  = ~aw_full_q & ~b_valid_q;
  assign W_READY   = ~w_full_q & ~b_valid_q;
  assign B_VALID   = b_valid_q;
  assign BRESPONSE = bresp_q;

  assign aw_hs  = AW_VALID & AW_READY;
  assign w_hs   = W_VALID & W_READY;
  assign aw_eff = aw_full_q | aw_hs;
  assign w_eff  = w_full_q | w_hs;

  // A channel landing this cycle is used directly so the
  // commit happens on the later handshake edge itself
  assign wr_addr = aw_full_q ? aw_q : write_address;
  assign wr_data = w_full_q ? w_q : data_write;

  assign rd_in_range = {1'b0, read_address} < NUM_LIM;
  assign wr_in_range = {1'b0, wr_addr} < NUM_LIM;

  axi_lite_regbank #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (bank_we),
    .waddr_i (wr_addr[IDX_W-1:0]),
    .wdata_i (wr_data),
    .raddr_i (read_address[IDX_W-1:0]),
    .rdata_o (bank_rdata)
  );

  // Read FSM next state: capture data on AR, clear on R
  always_comb begin
    rd_state_d = rd_state_q;
    rd_data_d  = rd_data_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (AR_VALID) begin
          rd_state_d = RD_RESP;
          rd_data_d  = rd_in_range ? bank_rdata : '0;
        end
      end
      RD_RESP: begin
        if (R_READY) begin
          rd_state_d = RD_IDLE;
          rd_data_d  = '0;
        end
      end
    endcase
  end

  // Read FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state_q <= RD_IDLE;
      rd_data_q  <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Write path: hold AW/W, commit when both present, B response
  always_comb begin
    aw_full_d = aw_full_q;
    aw_d      = aw_q;
    w_full_d  = w_full_q;
    w_d       = w_q;
    b_valid_d = b_valid_q;
    bresp_d   = bresp_q;
    bank_we   = 1'b0;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_d      = write_address;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_d      = data_write;
    end
    if (aw_eff && w_eff) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bank_we   = wr_in_range;
      b_valid_d = 1'b1;
      bresp_d   = wr_in_range ? RESP_OKAY : RESP_DECERR;
    end else if (b_valid_q && B_READY) begin
      b_valid_d = 1'b0;
      bresp_d   = RESP_OKAY;
    end
  end

  // Write path registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_full_q <= 1'b0;
      aw_q      <= '0;
      w_full_q  <= 1'b0;
      w_q       <= '0;
      b_valid_q <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      aw_full_q <= aw_full_d;
      aw_q      <= aw_d;
      w_full_q  <= w_full_d;
      w_q       <= w_d;
      b_valid_q <= b_valid_d;
      bresp_q   <= bresp_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Testbench for axi_lite_slave_regfile.
// Directed scenarios plus randomized traffic against an array model.
module tb_axi_lite_slave_regfile;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] read_address;
  logic          AR_VALID;
  logic          AR_READY;
  logic [DW-1:0] data_read;
  logic          R_VALID;
  logic          R_READY;
  logic [AW-1:0] write_address;
  logic          AW_VALID;
  logic          AW_READY;
  logic [DW-1:0] data_write;
  logic          W_VALID;
  logic          W_READY;
  logic          B_VALID;
  logic [3:0]    BRESPONSE;
  logic          B_READY;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [NR];

  axi_lite_slave_regfile #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .read_address  (read_address),
    .AR_VALID      (AR_VALID),
    .AR_READY      (AR_READY),
    .data_read     (data_read),
    .R_VALID       (R_VALID),
    .R_READY       (R_READY),
    .write_address (write_address),
    .AW_VALID      (AW_VALID),
    .AW_READY      (AW_READY),
    .data_write    (data_write),
    .W_VALID       (W_VALID),
    .W_READY       (W_READY),
    .B_VALID       (B_VALID),
    .BRESPONSE     (BRESPONSE),
    .B_READY       (B_READY)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_read(input logic [7:0] a);
    if (int'(a) < NR) return model[int'(a)];
    return 8'h00;
  endfunction

  function automatic logic [3:0] exp_resp(input logic [7:0] a);
    return (int'(a) < NR) ? 4'd0 : 4'd3;
  endfunction

  function automatic void model_write(input logic [7:0] a,
                                      input logic [7:0] d);
    if (int'(a) < NR) model[int'(a)] = d;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endfunction

  // Channel drivers: start and end just after a falling edge
  task automatic send_aw(input logic [7:0] a);
    int n;
    AW_VALID = 1'b1;
    write_address = a;
    n = 0;
    while (!AW_READY && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    AW_VALID = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] d);
    int n;
    W_VALID = 1'b1;
    data_write = d;
    n = 0;
    while (!W_READY && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    W_VALID = 1'b0;
  endtask

  // mode 0: AW+W together, 1: W first, 2: AW first
  task automatic axi_write(input logic [7:0] a,
                           input logic [7:0] d,
                           input int mode,
                           input int gap,
                           input int bdly,
                           output logic [3:0] resp,
                           output int lat,
                           output logic b_clear);
    int n;
    B_READY = 1'b0;
    if (mode == 0) begin
      AW_VALID = 1'b1;
      write_address = a;
      W_VALID = 1'b1;
      data_write = d;
      n = 0;
      while (!(AW_READY && W_READY) && n < 20) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      AW_VALID = 1'b0;
      W_VALID = 1'b0;
    end else begin
      if (mode == 1) send_w(d);
      else send_aw(a);
      repeat (gap) @(negedge clk);
      if (mode == 1) send_aw(a);
      else send_w(d);
    end
    n = 0;
    while (!B_VALID && n < 10) begin
      @(negedge clk);
      n++;
    end
    lat = B_VALID ? n : -1;
    resp = BRESPONSE;
    repeat (bdly) @(negedge clk);
    B_READY = 1'b1;
    @(negedge clk);
    b_clear = !B_VALID;
  endtask

  task automatic axi_read(input logic [7:0] a,
                          input int rdly,
                          output logic [7:0] d,
                          output int lat,
                          output logic r_clear,
                          output logic stable);
    int n;
    R_READY = 1'b0;
    AR_VALID = 1'b1;
    read_address = a;
    n = 0;
    while (!AR_READY && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    AR_VALID = 1'b0;
    n = 0;
    while (!R_VALID && n < 10) begin
      @(negedge clk);
      n++;
    end
    lat = R_VALID ? n : -1;
    d = data_read;
    stable = 1'b1;
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      if (!R_VALID || AR_READY || data_read !== d) stable = 1'b0;
    end
    R_READY = 1'b1;
    @(negedge clk);
    r_clear = !R_VALID;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    int lat;
    logic rc, st;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({AR_READY, AW_READY, W_READY} !== 3'b111) begin
      errors++;
      $display("FAIL reset_ready: got %b want 111",
               {AR_READY, AW_READY, W_READY});
    end
    checks++;
    if ({R_VALID, B_VALID} !== 2'b00) begin
      errors++;
      $display("FAIL reset_valid: got %b want 00",
               {R_VALID, B_VALID});
    end
    checks++;
    if (data_read !== 8'h00 || BRESPONSE !== 4'd0) begin
      errors++;
      $display("FAIL reset_data: data %h resp %0d want 0/0",
               data_read, BRESPONSE);
    end
    rst = 1'b1;
    @(negedge clk);
    model_clear();
    for (int i = 0; i < NR; i++) begin
      axi_read(8'(i), 0, d, lat, rc, st);
      checks++;
      if (d !== 8'h00 || lat !== 0) begin
        errors++;
        $display("FAIL reset_reg%0d: data %h lat %0d want 00/0",
                 i, d, lat);
      end
    end
  endtask

  task automatic test_write_readback();
    logic [3:0] resp;
    int lat;
    logic bc, rc, st;
    logic [7:0] d;
    axi_write(8'd3, 8'hA5, 0, 0, 0, resp, lat, bc);
    model_write(8'd3, 8'hA5);
    checks++;
    if (lat !== 0 || resp !== 4'd0 || bc !== 1'b1) begin
      errors++;
      $display("FAIL wr_rb_b: lat %0d resp %0d clr %b want 0/0/1",
               lat, resp, bc);
    end
    axi_read(8'd3, 0, d, lat, rc, st);
    checks++;
    if (lat !== 0 || d !== 8'hA5 || rc !== 1'b1) begin
      errors++;
      $display("FAIL wr_rb_r: lat %0d data %h clr %b want 0/a5/1",
               lat, d, rc);
    end
  endtask

  task automatic test_split_order();
    logic [7:0] d;
    int lat;
    logic rc, st;
    B_READY = 1'b0;
    W_VALID = 1'b1;
    data_write = 8'h3C;
    @(negedge clk);
    W_VALID = 1'b0;
    checks++;
    if ({W_READY, AW_READY, B_VALID} !== 3'b010) begin
      errors++;
      $display("FAIL split_w_held: W/AW/B got %b want 010",
               {W_READY, AW_READY, B_VALID});
    end
    @(negedge clk);
    checks++;
    if (B_VALID !== 1'b0 || W_READY !== 1'b0) begin
      errors++;
      $display("FAIL split_wait: B %b W_READY %b want 0/0",
               B_VALID, W_READY);
    end
    AW_VALID = 1'b1;
    write_address = 8'd5;
    @(negedge clk);
    AW_VALID = 1'b0;
    checks++;
    if (B_VALID !== 1'b1 || BRESPONSE !== 4'd0) begin
      errors++;
      $display("FAIL split_b: B %b resp %0d want 1/0",
               B_VALID, BRESPONSE);
    end
    B_READY = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (B_VALID !== 1'b0 || {AW_READY, W_READY} !== 2'b11) begin
      errors++;
      $display("FAIL split_single: B %b rdy %b want 0/11",
               B_VALID, {AW_READY, W_READY});
    end
    model_write(8'd5, 8'h3C);
    axi_read(8'd5, 0, d, lat, rc, st);
    checks++;
    if (d !== 8'h3C || lat !== 0) begin
      errors++;
      $display("FAIL split_read: data %h lat %0d want 3c/0", d, lat);
    end
  endtask

  task automatic test_out_of_range();
    logic [3:0] resp;
    int lat;
    logic bc, rc, st;
    logic [7:0] d;
    axi_write(8'd16, 8'hFF, 0, 0, 0, resp, lat, bc);
    checks++;
    if (resp !== 4'd3 || lat !== 0) begin
      errors++;
      $display("FAIL oor_resp: resp %0d lat %0d want 3/0", resp, lat);
    end
    for (int i = 0; i < NR; i++) begin
      axi_read(8'(i), 0, d, lat, rc, st);
      checks++;
      if (d !== exp_read(8'(i))) begin
        errors++;
        $display("FAIL oor_reg%0d: got %h want %h",
                 i, d, exp_read(8'(i)));
      end
    end
    axi_read(8'd200, 0, d, lat, rc, st);
    checks++;
    if (d !== 8'h00 || lat !== 0) begin
      errors++;
      $display("FAIL oor_read: data %h lat %0d want 00/0", d, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d;
    int lat;
    logic rc, st;
    axi_read(8'd3, 4, d, lat, rc, st);
    checks++;
    if (d !== exp_read(8'd3) || st !== 1'b1 || rc !== 1'b1) begin
      errors++;
      $display("FAIL bp_read: data %h stable %b clr %b want %h/1/1",
               d, st, rc, exp_read(8'd3));
    end
    B_READY = 1'b0;
    AW_VALID = 1'b1;
    write_address = 8'd6;
    W_VALID = 1'b1;
    data_write = 8'h77;
    @(negedge clk);
    AW_VALID = 1'b0;
    W_VALID = 1'b0;
    model_write(8'd6, 8'h77);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({B_VALID, AW_READY, W_READY} !== 3'b100) begin
        errors++;
        $display("FAIL bp_b_cyc%0d: B/AW/W got %b want 100",
                 i, {B_VALID, AW_READY, W_READY});
      end
      @(negedge clk);
    end
    B_READY = 1'b1;
    @(negedge clk);
    checks++;
    if ({B_VALID, AW_READY, W_READY} !== 3'b011) begin
      errors++;
      $display("FAIL bp_b_release: B/AW/W got %b want 011",
               {B_VALID, AW_READY, W_READY});
    end
  endtask

  task automatic test_collision();
    logic [3:0] resp;
    int lat;
    logic bc, rc, st;
    logic [7:0] d;
    axi_write(8'd7, 8'h11, 0, 0, 0, resp, lat, bc);
    model_write(8'd7, 8'h11);
    R_READY = 1'b1;
    B_READY = 1'b1;
    AR_VALID = 1'b1;
    read_address = 8'd7;
    AW_VALID = 1'b1;
    write_address = 8'd7;
    W_VALID = 1'b1;
    data_write = 8'h22;
    checks++;
    if ({AR_READY, AW_READY, W_READY} !== 3'b111) begin
      errors++;
      $display("FAIL coll_ready: got %b want 111",
               {AR_READY, AW_READY, W_READY});
    end
    @(negedge clk);
    AR_VALID = 1'b0;
    AW_VALID = 1'b0;
    W_VALID = 1'b0;
    checks++;
    if (R_VALID !== 1'b1 || data_read !== 8'h11) begin
      errors++;
      $display("FAIL coll_old: R %b data %h want 1/11",
               R_VALID, data_read);
    end
    checks++;
    if (B_VALID !== 1'b1 || BRESPONSE !== 4'd0) begin
      errors++;
      $display("FAIL coll_b: B %b resp %0d want 1/0",
               B_VALID, BRESPONSE);
    end
    @(negedge clk);
    model_write(8'd7, 8'h22);
    axi_read(8'd7, 0, d, lat, rc, st);
    checks++;
    if (d !== 8'h22) begin
      errors++;
      $display("FAIL coll_new: data %h want 22", d);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, dat, d;
    logic [3:0] resp;
    int lat, mode, gap, dly;
    logic clr, st;
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 255));
      else a = 8'($urandom_range(0, 19));
      dat = 8'($urandom);
      mode = $urandom_range(0, 2);
      gap = $urandom_range(0, 2);
      dly = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 0) begin
        axi_write(a, dat, mode, gap, dly, resp, lat, clr);
        checks++;
        if (lat !== 0 || resp !== exp_resp(a) || clr !== 1'b1) begin
          errors++;
          $display("FAIL rnd_wr it%0d a%0d: lat %0d resp %0d clr %b want 0/%0d/1",
                   it, a, lat, resp, clr, exp_resp(a));
        end
        model_write(a, dat);
      end else begin
        axi_read(a, dly, d, lat, clr, st);
        checks++;
        if (lat !== 0 || d !== exp_read(a) || clr !== 1'b1 || st !== 1'b1) begin
          errors++;
          $display("FAIL rnd_rd it%0d a%0d: data %h lat %0d clr %b st %b want %h/0/1/1",
                   it, a, d, lat, clr, st, exp_read(a));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int lat;
    logic rc, st;
    R_READY = 1'b0;
    AR_VALID = 1'b1;
    read_address = 8'd3;
    @(negedge clk);
    AR_VALID = 1'b0;
    AW_VALID = 1'b1;
    write_address = 8'd4;
    @(negedge clk);
    AW_VALID = 1'b0;
    checks++;
    if ({R_VALID, AW_READY, W_READY} !== 3'b101) begin
      errors++;
      $display("FAIL rstmid_pre: R/AW/W got %b want 101",
               {R_VALID, AW_READY, W_READY});
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({AR_READY, AW_READY, W_READY, R_VALID, B_VALID} !== 5'b11100
        || data_read !== 8'h00 || BRESPONSE !== 4'd0) begin
      errors++;
      $display("FAIL rstmid_async: flags %b data %h resp %0d want 11100/00/0",
               {AR_READY, AW_READY, W_READY, R_VALID, B_VALID},
               data_read, BRESPONSE);
    end
    @(negedge clk);
    rst = 1'b1;
    R_READY = 1'b1;
    B_READY = 1'b1;
    model_clear();
    send_w(8'h5A);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (B_VALID !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_nob%0d: B %b want 0", i, B_VALID);
      end
      @(negedge clk);
    end
    send_aw(8'd9);
    checks++;
    if (B_VALID !== 1'b1 || BRESPONSE !== 4'd0) begin
      errors++;
      $display("FAIL rstmid_b: B %b resp %0d want 1/0",
               B_VALID, BRESPONSE);
    end
    @(negedge clk);
    model_write(8'd9, 8'h5A);
    for (int i = 0; i < NR; i++) begin
      axi_read(8'(i), 0, d, lat, rc, st);
      checks++;
      if (d !== exp_read(8'(i))) begin
        errors++;
        $display("FAIL rstmid_reg%0d: got %h want %h",
                 i, d, exp_read(8'(i)));
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    read_address = '0;
    AR_VALID = 1'b0;
    R_READY = 1'b1;
    write_address = '0;
    AW_VALID = 1'b0;
    data_write = '0;
    W_VALID = 1'b0;
    B_READY = 1'b1;
    test_reset();
    test_write_readback();
    test_split_order();
    test_out_of_range();
    test_backpressure();
    test_collision();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
